pico_branch_unit: RTL and testbench

//  Consumer side of the pico ALU flag interface: latches the 4-bit ALU flags {Z,N,V,C}
//  and resolves conditional-branch requests from the control FSM against them. It

---
 rtl/pico_pkg.sv | 65 ++++++
 rtl/pico_cond_eval.sv | 50 +++++
 rtl/pico_branch_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_pico_branch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_pkg.sv
// pico_pkg
//  Shared definitions for the pico core datapath/control slice:
//   - flag bit positions inside the 4-bit ALU flag word {Z,N,V,C}
//   - cond_e: branch condition-code encoding used by the control FSM
//   - state_e: states of the branch-unit request FSM
//   - pico_F_* ALU operation codes shared with the ALU
//   - pico_pack_flags: helper that assembles a flag word from single bits
package pico_pkg;

  // Flag word bit positions.
  localparam int unsigned FLG_Z = 32'd3;
  localparam int unsigned FLG_N = 32'd2;
  localparam int unsigned FLG_V = 32'd1;
  localparam int unsigned FLG_C = 32'd0;

  // Branch condition codes.
  typedef enum logic [3:0] {
    COND_AL = 4'd0,   // always
    COND_EQ = 4'd1,   // Z
    COND_NE = 4'd2,   // ~Z
    COND_CS = 4'd3,   // C
    COND_CC = 4'd4,   // ~C
    COND_MI = 4'd5,   // N
    COND_PL = 4'd6,   // ~N
    COND_VS = 4'd7,   // V
    COND_VC = 4'd8,   // ~V
    COND_HI = 4'd9,   // C & ~Z
    COND_LS = 4'd10,  // ~C | Z
    COND_GE = 4'd11,  // N == V
    COND_LT = 4'd12,  // N != V
    COND_GT = 4'd13,  // ~Z & (N == V)
    COND_LE = 4'd14,  // Z | (N != V)
    COND_NV = 4'd15   // never
  } cond_e;

  // Branch-unit request FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  // ALU operation codes (shared with the ALU that produces the flags).
  localparam logic [3:0] pico_F_ADD = 4'h0;
  localparam logic [3:0] pico_F_SUB = 4'h1;
  localparam logic [3:0] pico_F_AND = 4'h2;
  localparam logic [3:0] pico_F_OR  = 4'h3;
  localparam logic [3:0] pico_F_XOR = 4'h4;
  localparam logic [3:0] pico_F_SHL = 4'h5;
  localparam logic [3:0] pico_F_SHR = 4'h6;
  localparam logic [3:0] pico_F_CMP = 4'h7;

  // Assemble a flag word from individual flag bits.
  function automatic logic [3:0] pico_pack_flags(input logic z, input logic n,
                                                 input logic v, input logic c);
    logic [3:0] w;
    w        = 4'h0;
    w[FLG_Z] = z;
    w[FLG_N] = n;
    w[FLG_V] = v;
    w[FLG_C] = c;
    return w;
  endfunction

endpackage

// File: rtl/pico_cond_eval.sv
// pico_cond_eval
//  Purely combinational condition evaluator: decides whether a branch with
//  condition code cond_i is taken given the flag word flags_i.
// Ports
//  flags_i  in  4  flag word {Z,N,V,C}
//  cond_i   in  4  condition code (pico_pkg::cond_e)
//  taken_o  out 1  condition holds
module pico_cond_eval
  import pico_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);

  logic z_s;
  logic n_s;
  logic v_s;
  logic c_s;

  assign z_s = flags_i[FLG_Z];
  assign n_s = flags_i[FLG_N];
  assign v_s = flags_i[FLG_V];
  assign c_s = flags_i[FLG_C];

  // Decode the condition code against the flag bits.
  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_AL: taken_o = 1'b1;
      COND_EQ: taken_o = z_s;
      COND_NE: taken_o = ~z_s;
      COND_CS: taken_o = c_s;
      COND_CC: taken_o = ~c_s;
      COND_MI: taken_o = n_s;
      COND_PL: taken_o = ~n_s;
      COND_VS: taken_o = v_s;
      COND_VC: taken_o = ~v_s;
      COND_HI: taken_o = c_s & ~z_s;
      COND_LS: taken_o = ~c_s | z_s;
      COND_GE: taken_o = (n_s == v_s);
      COND_LT: taken_o = (n_s != v_s);
      COND_GT: taken_o = ~z_s & (n_s == v_s);
      COND_LE: taken_o = z_s | (n_s != v_s);
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pico_branch_unit.sv
// pico_branch_unit
//  Latches the ALU flags {Z,N,V,C} and resolves conditional-branch requests
//  against them. A request is accepted in IDLE, evaluated in EVAL (stalling
//  while the flags are being rewritten) and the decision is offered in RESP
//  until the consumer takes it. Minimum latency accept->resp_valid_o is two
//  clocks; at most one request every three clocks.
//
//  Optional feature macro: PICO_FLAG_STACK_EN
//   When defined, a STACK_D-deep LIFO of flag words is added for interrupt
//   save/restore (ports push_i, pop_i, stk_err_o). When undefined those ports
//   and the storage do not exist.
//
// Parameters
//  PC_W     program counter width (offset is 8-bit signed, sign-extended)
//  STACK_D  flag-stack depth (only used with PICO_FLAG_STACK_EN)
// Ports
//  clk_i, rst_i         clock, synchronous active-high reset
//  flag_we_i, flag_i    flag register write enable / ALU flags
//  req_valid_i/ready_o  branch request handshake (ready only in IDLE)
//  req_cond_i           condition code (pico_pkg::cond_e)
//  req_pc_i, req_off_i  branch PC and signed 8-bit offset
//  resp_valid_o/ready_i decision handshake
//  resp_taken_o         condition was true
//  resp_target_o        next PC (pc+sext(off) if taken, else pc+1, wrapping)
//  push_i, pop_i        flag save/restore (stack build only)
//  stk_err_o            one-cycle stack overflow/underflow pulse (stack build only)
//  flags_o              current flag register
module pico_branch_unit
  import pico_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned STACK_D = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flag_we_i,
  input  logic [3:0]      flag_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      req_cond_i,
  input  logic [PC_W-1:0] req_pc_i,
  input  logic [7:0]      req_off_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic            resp_taken_o,
  output logic [PC_W-1:0] resp_target_o,
`ifdef PICO_FLAG_STACK_EN
  input  logic            push_i,
  input  logic            pop_i,
  output logic            stk_err_o,
`endif
  output logic [3:0]      flags_o
);

  state_e          state_q,      state_d;
  logic [3:0]      cond_q,       cond_d;
  logic [PC_W-1:0] pc_q,         pc_d;
  logic [7:0]      off_q,        off_d;
  logic            taken_q,      taken_d;
  logic [PC_W-1:0] target_q,     target_d;
  logic            resp_valid_q, resp_valid_d;
  logic [3:0]      flags_q,      flags_d;

  logic            cond_taken_s;
  logic            eval_stall_s;
  logic [PC_W-1:0] off_sext_s;
  logic [PC_W-1:0] br_target_s;
  logic [PC_W-1:0] seq_target_s;

  pico_cond_eval u_cond_eval (
    .flags_i (flags_q),
    .cond_i  (cond_q),
    .taken_o (cond_taken_s)
  );

  // Size cast of a signed value sign-extends the offset to PC_W.
  assign off_sext_s   = PC_W'($signed(off_q));
  assign br_target_s  = pc_q + off_sext_s;
  assign seq_target_s = pc_q + PC_W'(1'b1);

  // Request FSM: accept in IDLE, evaluate in EVAL, hold decision in RESP.
  always_comb begin
    state_d      = state_q;
    cond_d       = cond_q;
    pc_d         = pc_q;
    off_d        = off_q;
    taken_d      = taken_q;
    target_d     = target_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cond_d  = req_cond_i;
          pc_d    = req_pc_i;
          off_d   = req_off_i;
          state_d = EVAL;
        end else begin
          state_d = IDLE;
        end
      end
      EVAL: begin
        // Flags changing this cycle: evaluate again once they have settled.
        if (eval_stall_s) begin
          state_d = EVAL;
        end else begin
          taken_d      = cond_taken_s;
          target_d     = cond_taken_s ? br_target_s : seq_target_s;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // FSM, captured request, response and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cond_q       <= 4'h0;
      pc_q         <= '0;
      off_q        <= 8'h00;
      taken_q      <= 1'b0;
      target_q     <= '0;
      resp_valid_q <= 1'b0;
      flags_q      <= 4'h0;
    end else begin
      state_q      <= state_d;
      cond_q       <= cond_d;
      pc_q         <= pc_d;
      off_q        <= off_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      resp_valid_q <= resp_valid_d;
      flags_q      <= flags_d;
    end
  end

`ifdef PICO_FLAG_STACK_EN
  localparam int unsigned CNT_W = $clog2(STACK_D + 1);
  localparam int unsigned IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [3:0]       stk_q [STACK_D];
  logic [3:0]       stk_d [STACK_D];
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             stk_err_q, stk_err_d;
  logic             stk_empty_s;
  logic             stk_full_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] push_idx_s;
  logic [3:0]       flags_wr_s;

  assign stk_empty_s = (cnt_q == CNT_W'(0));
  assign stk_full_s  = (cnt_q == CNT_W'(STACK_D));
  // Only used when the stack is non-empty (top) or not full (push).
  assign top_idx_s   = IDX_W'(cnt_q - CNT_W'(1));
  assign push_idx_s  = IDX_W'(cnt_q);
  assign flags_wr_s  = flag_we_i ? flag_i : flags_q;
  // A pop rewrites the flags just like an ALU write, so EVAL must wait.
  assign eval_stall_s = flag_we_i | pop_i;

  // Flag register and LIFO update; pop wins over an ALU flag write.
  always_comb begin
    flags_d   = flags_wr_s;
    stk_d     = stk_q;
    cnt_d     = cnt_q;
    stk_err_d = 1'b0;
    if (push_i && pop_i) begin
      // Swap current flags with the top entry; needs a top entry.
      if (stk_empty_s) begin
        stk_err_d = 1'b1;
      end else begin
        stk_d[top_idx_s] = flags_q;
        flags_d          = stk_q[top_idx_s];
      end
    end else if (push_i) begin
      // Save the value the flag register is about to hold.
      if (stk_full_s) begin
        stk_err_d = 1'b1;
      end else begin
        stk_d[push_idx_s] = flags_wr_s;
        cnt_d             = cnt_q + CNT_W'(1);
      end
    end else if (pop_i) begin
      if (stk_empty_s) begin
        stk_err_d = 1'b1;
      end else begin
        flags_d = stk_q[top_idx_s];
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end else begin
      stk_err_d = 1'b0;
    end
  end

  // Stack storage, occupancy and error-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STACK_D; i++) begin
        stk_q[i] <= 4'h0;
      end
      cnt_q     <= '0;
      stk_err_q <= 1'b0;
    end else begin
      stk_q     <= stk_d;
      cnt_q     <= cnt_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign stk_err_o = stk_err_q;
`else
  assign eval_stall_s = flag_we_i;

  // Flag register next value: an ALU write replaces the flags.
  always_comb begin
    if (flag_we_i) begin
      flags_d = flag_i;
    end else begin
      flags_d = flags_q;
    end
  end

  // Without the stack the depth parameter has no storage behind it.
  if (STACK_D == 0) begin : g_no_stack_depth
  end
`endif

  assign req_ready_o   = (state_q == IDLE);
  assign resp_valid_o  = resp_valid_q;
  assign resp_taken_o  = taken_q;
  assign resp_target_o = target_q;
  assign flags_o       = flags_q;

endmodule

// File: tb/tb_pico_branch_unit.sv
// Self-checking bench for pico_branch_unit: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level reference model.
module tb_pico_branch_unit;

  localparam int PC_W    = 8;
  localparam int STACK_D = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flag_we_i;
  logic [3:0]      flag_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [3:0]      req_cond_i;
  logic [PC_W-1:0] req_pc_i;
  logic [7:0]      req_off_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic            resp_taken_o;
  logic [PC_W-1:0] resp_target_o;
  logic [3:0]      flags_o;
`ifdef PICO_FLAG_STACK_EN
  logic            push_i;
  logic            pop_i;
  logic            stk_err_o;
`endif

  always #5 clk_i = ~clk_i;

  pico_branch_unit #(.PC_W(PC_W), .STACK_D(STACK_D)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flag_we_i     (flag_we_i),
    .flag_i        (flag_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_cond_i    (req_cond_i),
    .req_pc_i      (req_pc_i),
    .req_off_i     (req_off_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_taken_o  (resp_taken_o),
    .resp_target_o (resp_target_o),
`ifdef PICO_FLAG_STACK_EN
    .push_i        (push_i),
    .pop_i         (pop_i),
    .stk_err_o     (stk_err_o),
`endif
    .flags_o       (flags_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state (transaction level).
  logic [3:0] m_flags;
  bit         m_busy;     // request accepted, decision not yet made
  bit         m_valid;    // decision on offer
  bit         m_taken;
  logic [7:0] m_target;
  logic [3:0] m_cond;
  logic [7:0] m_pc;
  logic [7:0] m_off;
  bit         m_err;
  logic [3:0] m_stk[$];

  // Condition rules: codes come in (true, negated) pairs around a base predicate.
  function automatic bit cond_true(input logic [3:0] f, input logic [3:0] code);
    bit z, n, v, c, base;
    int k;
    z = f[3]; n = f[2]; v = f[1]; c = f[0];
    k = int'(code);
    if (k == 0) return 1'b1;
    if (k == 15) return 1'b0;
    if (k <= 8) begin
      case ((k - 1) / 2)
        0: base = z;
        1: base = c;
        2: base = n;
        default: base = v;
      endcase
    end else begin
      case ((k - 9) / 2)
        0: base = c & ~z;
        1: base = (n == v);
        default: base = ~z & (n == v);
      endcase
    end
    return (k % 2 == 1) ? base : !base;
  endfunction

  function automatic logic [7:0] calc_target(input bit tk, input logic [7:0] pc,
                                             input logic [7:0] off);
    int s, t;
    s = (off >= 8'd128) ? int'(off) - 256 : int'(off);
    t = tk ? int'(pc) + s : int'(pc) + 1;
    return 8'((t + 512) % 256);
  endfunction

  task automatic model_step();
    logic [3:0] nf;
    logic [3:0] tmp;
    bit stall;
    bit err;
    if (rst_i) begin
      m_flags = 4'h0; m_busy = 1'b0; m_valid = 1'b0; m_taken = 1'b0;
      m_target = 8'h00; m_err = 1'b0; m_stk.delete();
    end else begin
      stall = flag_we_i;
`ifdef PICO_FLAG_STACK_EN
      stall = stall | pop_i;
`endif
      if (m_valid) begin
        if (resp_ready_i) m_valid = 1'b0;
      end else if (m_busy) begin
        if (!stall) begin
          m_taken  = cond_true(m_flags, m_cond);
          m_target = calc_target(m_taken, m_pc, m_off);
          m_valid  = 1'b1;
          m_busy   = 1'b0;
        end
      end else if (req_valid_i) begin
        m_cond = req_cond_i; m_pc = req_pc_i; m_off = req_off_i;
        m_busy = 1'b1;
      end
      nf  = flag_we_i ? flag_i : m_flags;
      err = 1'b0;
`ifdef PICO_FLAG_STACK_EN
      if (push_i && pop_i) begin
        if (m_stk.size() == 0) err = 1'b1;
        else begin
          tmp = m_stk[m_stk.size() - 1];
          m_stk[m_stk.size() - 1] = m_flags;
          nf = tmp;
        end
      end else if (push_i) begin
        if (m_stk.size() == STACK_D) err = 1'b1;
        else m_stk.push_back(nf);
      end else if (pop_i) begin
        if (m_stk.size() == 0) err = 1'b1;
        else nf = m_stk.pop_back();
      end
`endif
      m_flags = nf;
      m_err   = err;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("req_ready", {31'd0, req_ready_o}, {31'd0, (!m_busy && !m_valid)});
    chk("resp_valid", {31'd0, resp_valid_o}, {31'd0, m_valid});
    chk("flags", {28'd0, flags_o}, {28'd0, m_flags});
    if (m_valid) begin
      chk("resp_taken", {31'd0, resp_taken_o}, {31'd0, m_taken});
      chk("resp_target", {24'd0, resp_target_o}, {24'd0, m_target});
    end
`ifdef PICO_FLAG_STACK_EN
    chk("stk_err", {31'd0, stk_err_o}, {31'd0, m_err});
`endif
  endtask

  // One clock: DUT and model step on the rising edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare();
  endtask

  task automatic send(input logic [3:0] cond, input logic [7:0] pc, input logic [7:0] off);
    req_valid_i = 1'b1; req_cond_i = cond; req_pc_i = pc; req_off_i = off;
    cycle();
    req_valid_i = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready_i = 1'b1;
    cycle();
    resp_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flag_we_i = 1'b0; flag_i = 4'h0; req_valid_i = 1'b0;
    req_cond_i = 4'h0; req_pc_i = 8'h00; req_off_i = 8'h00; resp_ready_i = 1'b0;
`ifdef PICO_FLAG_STACK_EN
    push_i = 1'b0; pop_i = 1'b0;
`endif
    cycle(); cycle();
    rst_i = 1'b0;

    // Reset with flags set and a request in flight.
    flag_we_i = 1'b1; flag_i = 4'hF; cycle(); flag_we_i = 1'b0;
    send(4'd0, 8'h20, 8'h01);
    rst_i = 1'b1; cycle(); rst_i = 1'b0;
    chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_flags", {28'd0, flags_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    repeat (3) cycle();
    chk("rst_no_resp", {31'd0, resp_valid_o}, 32'd0);

    // BEQ with Z set: two-cycle latency, taken, backward target.
    flag_we_i = 1'b1; flag_i = 4'b1000; cycle(); flag_we_i = 1'b0;
    send(4'd1, 8'h10, 8'hFC);
    chk("beq_t1_valid", {31'd0, resp_valid_o}, 32'd0);
    cycle();
    chk("beq_valid", {31'd0, resp_valid_o}, 32'd1);
    chk("beq_taken", {31'd0, resp_taken_o}, 32'd1);
    chk("beq_target", {24'd0, resp_target_o}, 32'h0C);
    chk("model_beq_target", {24'd0, m_target}, 32'h0C);
    release_resp();
    chk("beq_drop", {31'd0, resp_valid_o}, 32'd0);

    // BNE with Z set: not taken, held stable under back-pressure.
    send(4'd2, 8'h10, 8'h40);
    cycle();
    for (int i = 0; i < 6; i++) begin
      chk("bne_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("bne_taken", {31'd0, resp_taken_o}, 32'd0);
      chk("bne_target", {24'd0, resp_target_o}, 32'h11);
      if (i < 5) cycle();
    end
    release_resp();

    // BLT with flag write during EVAL: one-cycle delay, uses new flags.
    send(4'd12, 8'h30, 8'h05);
    flag_we_i = 1'b1; flag_i = 4'b0100; cycle(); flag_we_i = 1'b0;
    chk("blt_stalled", {31'd0, resp_valid_o}, 32'd0);
    cycle();
    chk("blt_valid", {31'd0, resp_valid_o}, 32'd1);
    chk("blt_taken", {31'd0, resp_taken_o}, 32'd1);
    chk("blt_target", {24'd0, resp_target_o}, 32'h35);
    chk("model_blt_taken", {31'd0, m_taken}, 32'd1);
    release_resp();

    // PC wrap-around for taken and not-taken targets.
    send(4'd0, 8'hFF, 8'h02); cycle();
    chk("wrap_al_target", {24'd0, resp_target_o}, 32'h01);
    release_resp();
    send(4'd15, 8'hFF, 8'h02); cycle();
    chk("wrap_nv_taken", {31'd0, resp_taken_o}, 32'd0);
    chk("wrap_nv_target", {24'd0, resp_target_o}, 32'h00);
    release_resp();

`ifdef PICO_FLAG_STACK_EN
    // Fill the stack, overflow once, then drain in LIFO order and underflow.
    for (int i = 0; i < 4; i++) begin
      push_i = 1'b1; flag_we_i = 1'b1; flag_i = 4'(i + 3); cycle();
    end
    flag_we_i = 1'b0; cycle();
    chk("stk_full_err", {31'd0, stk_err_o}, 32'd1);
    push_i = 1'b0; cycle();
    chk("stk_err_pulse", {31'd0, stk_err_o}, 32'd0);
    pop_i = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      cycle();
      chk("stk_pop_order", {28'd0, flags_o}, 32'(i + 3));
    end
    cycle();
    chk("stk_empty_err", {31'd0, stk_err_o}, 32'd1);
    chk("stk_empty_flags", {28'd0, flags_o}, 32'd3);
    pop_i = 1'b0; cycle();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_i        = ($urandom_range(0, 255) == 0);
      req_valid_i  = $urandom_range(0, 1) == 1;
      req_cond_i   = 4'($urandom_range(0, 15));
      req_pc_i     = 8'($urandom_range(0, 255));
      req_off_i    = 8'($urandom_range(0, 255));
      flag_we_i    = ($urandom_range(0, 3) == 0);
      flag_i       = 4'($urandom_range(0, 15));
      resp_ready_i = $urandom_range(0, 1) == 1;
`ifdef PICO_FLAG_STACK_EN
      push_i       = ($urandom_range(0, 7) == 0);
      pop_i        = ($urandom_range(0, 7) == 0);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
